dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port data memory (64-bit words, 256 entries).
- Port 0 is the CPU load/store stage; port 1 is the debug/DMA loader.
- Accepts one request at a time using valid/ready, drives the memory read and write strobes for exactly one cycle, and returns a registered response with backpressure.
- Ties are resolved round-robin.

Parameters:
- n, 64, data word width and memory address bus width.
- AW, 8, significant word-address bits (memory depth 2^AW = 256).

Ports:
- clk  in  1  system clock, all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  port 0 request present.
- req0_ready  out  1  port 0 request accepted this cycle.
- req0_we  in  1  port 0 request type: 1 = write, 0 = read.
- req0_addr  in  AW  port 0 word address.
- req0_wdata  in  n  port 0 write data.
- rsp0_valid  out  1  port 0 response available.
- rsp0_ready  in  1  port 0 consumes the response.
- rsp0_rdata  out  n  port 0 read data; 0 for writes.
- req1_valid, req1_ready, req1_we, req1_addr, req1_wdata, rsp1_valid, rsp1_ready, rsp1_rdata: same as port 0, for port 1.
- mem_addr  out  n  memory address; AW bits zero-extended to n.
- mem_wdata  out  n  memory write data.
- mem_read  out  1  memory read enable.
- mem_write  out  1  memory write enable.
- mem_rdata  in  n  memory read data; combinational from mem_addr while mem_read = 1.

Behaviour:
- FSM states: IDLE, ACCESS, RESP.
  - Reset state is IDLE.
  - Internal registers: gnt (index of the latched requester) and last (index of the previous winner). last resets to 1, so port 0 wins the first tie.
- IDLE:
  - If neither valid is high, stay in IDLE.
  - If exactly one valid is high, that port wins.
  - If both are high, the port != last wins.
  - reqX_ready is asserted combinationally, in the same cycle, for the winner only.
  - On that edge: latch we, addr, wdata; set gnt = winner and last = winner; go to ACCESS.
  - reqX_ready is never high outside IDLE and never high for both ports.
- ACCESS (exactly 1 cycle):
  - mem_addr = {0, latched addr}; mem_wdata = latched wdata.
  - mem_read = ~we and mem_write = we. At most one of them is high.
  - On the edge: a write commits in memory; a read captures mem_rdata into the response register (writes capture 0); go to RESP.
- RESP:
  - rsp[gnt]_valid = 1 with the captured data. The other port's rsp_valid stays 0.
  - Hold valid and data stable until rsp[gnt]_ready = 1 on an edge, then go to IDLE.
  - A new request is not accepted in the same cycle as the response handshake.
- Timing:
  - Handshake at edge T gives rsp_valid high from T+2.
  - Peak throughput is one access per 3 cycles.
  - A back-to-back read after a write to the same address returns the new data.
- Outside ACCESS: mem_read = mem_write = 0; mem_addr and mem_wdata hold the last latched values (0 after reset).
- Requester rule: req fields stay stable while valid is high and ready is low. The arbiter samples req fields only on the handshake edge.
- Reset:
  - rst_n low asynchronously forces IDLE, last = 1, gnt = 0, and clears all latched fields and the response register.
  - All outputs go to 0 immediately: readies, rsp valids, rdata, mem strobes, mem_addr and mem_wdata.
  - Reset asserted in ACCESS before the edge means no write commits and the pending request is dropped without a response.
  - Reset asserted in RESP discards the response.
- Fairness: with both ports requesting continuously, grants strictly alternate 0,1,0,1…

Test Plan:
- Port 0 write addr 0x05 data 0xDEADBEEF_CAFEF00D, then read 0x05 -> req0_ready high in the IDLE cycle; mem_write high for exactly one cycle; read response rsp0_rdata = 0xDEADBEEF_CAFEF00D at T+2; rsp1_valid stays 0 throughout.
- Both valid every cycle, reads of 0x10 (port 0) and 0x20 (port 1), responses always ready -> grant order 0,1,0,1; a new grant every 3 cycles; mem_addr alternates 0x10/0x20; req0_ready and req1_ready never high together.
- Port 1 read with rsp1_ready held low for 5 cycles -> rsp1_valid and rsp1_rdata stable for 5 cycles; no new ready issued; returns to IDLE on the edge where rsp1_ready is high.
- Port 0 write of 0x1234 to addr 0x07 (old contents 0x0), rst_n pulsed low during ACCESS before the edge -> all outputs 0 immediately; a later read of 0x07 returns 0x0; the first tie after reset goes to port 0.
- Port 0 access to addr 0xFF -> mem_addr = 0x00000000_000000FF (upper bits zero); read data returned correctly.
- Write from port 1 -> rsp1_valid high with rsp1_rdata = 0; mem_read never asserted.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port sequencer in front of a single-port data memory.
// Accepts one request at a time, strobes the memory for one cycle, then holds a registered response.
module dmem_arbiter #(
  parameter int n  = 64,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic          req0_we,
  input  logic [AW-1:0] req0_addr,
  input  logic [n-1:0]  req0_wdata,
  output logic          rsp0_valid,
  input  logic          rsp0_ready,
  output logic [n-1:0]  rsp0_rdata,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic          req1_we,
  input  logic [AW-1:0] req1_addr,
  input  logic [n-1:0]  req1_wdata,
  output logic          rsp1_valid,
  input  logic          rsp1_ready,
  output logic [n-1:0]  rsp1_rdata,
  output logic [n-1:0]  mem_addr,
  output logic [n-1:0]  mem_wdata,
  output logic          mem_read,
  output logic          mem_write,
  input  logic [n-1:0]  mem_rdata
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_nx;
  logic gnt, last, we_q, win, hs, rsp_hs;
  logic [AW-1:0] addr_q;
  logic [n-1:0] wdata_q, rdata_q;
  // On a tie the port that did not win last time goes next
  assign win = (req0_valid && req1_valid) ? ~last : req1_valid;
  assign hs = state == IDLE && (req0_valid || req1_valid);
  assign req0_ready = rst_n && hs && !win;
  assign req1_ready = rst_n && hs && win;
  assign rsp_hs = gnt ? rsp1_ready : rsp0_ready;
  assign mem_addr = {{(n-AW){1'b0}}, addr_q};
  assign mem_wdata = wdata_q;
  assign mem_read = state == ACCESS && !we_q;
  assign mem_write = state == ACCESS && we_q;
  assign rsp0_valid = state == RESP && !gnt;
  assign rsp1_valid = state == RESP && gnt;
  assign rsp0_rdata = rsp0_valid ? rdata_q : '0;
  assign rsp1_rdata = rsp1_valid ? rdata_q : '0;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = hs ? ACCESS : IDLE;
      ACCESS:  state_nx = RESP;
      RESP:    state_nx = rsp_hs ? IDLE : RESP;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt <= 1'b0;
      last <= 1'b1;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nx;
      if (hs) begin
        gnt <= win;
        last <= win;
        we_q <= win ? req1_we : req0_we;
        addr_q <= win ? req1_addr : req0_addr;
        wdata_q <= win ? req1_wdata : req0_wdata;
      end
      if (state == ACCESS) rdata_q <= we_q ? '0 : mem_rdata;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scenario tasks plus randomized traffic checked against a transaction-level model.
module tb_dmem_arbiter;
  logic clk, rst_n;
  logic req0_valid, req0_ready, req0_we, rsp0_valid, rsp0_ready;
  logic req1_valid, req1_ready, req1_we, rsp1_valid, rsp1_ready;
  logic [7:0] req0_addr, req1_addr;
  logic [63:0] req0_wdata, req1_wdata, rsp0_rdata, rsp1_rdata;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic mem_read, mem_write;
  logic [63:0] mem [256];
  logic [63:0] ref_mem [256];
  logic [261:0] all_out;
  bit last_m;
  int errors = 0, checks = 0;

  typedef struct {
    bit r0, r1, rd, wr, bad, unst, v0, v1, idle;
    logic [63:0] addr, wdata, d0, d1;
  } obs_t;

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_rdata(rsp1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial for (int i = 0; i < 256; i++) mem[i] = '0;
  always @(posedge clk) if (mem_write) mem[mem_addr[7:0]] <= mem_wdata;
  assign mem_rdata = mem_read ? mem[mem_addr[7:0]] : '0;
  assign all_out = {req0_ready, req1_ready, rsp0_valid, rsp1_valid, mem_read, mem_write,
                    rsp0_rdata, rsp1_rdata, mem_addr, mem_wdata};

  // Drives one request pattern from IDLE through the response handshake and records what was seen.
  task automatic run_txn(input bit v0, v1, w0, w1, input logic [7:0] a0, a1,
                         input logic [63:0] d0, d1, input int hold, output obs_t o);
    logic [63:0] s0, s1;
    bit sv0, sv1;
    o.bad = 0; o.unst = 0;
    s0 = '0; s1 = '0; sv0 = 0; sv1 = 0;
    @(posedge clk); #1;
    req0_valid = v0; req1_valid = v1; req0_we = w0; req1_we = w1;
    req0_addr = a0; req1_addr = a1; req0_wdata = d0; req1_wdata = d1;
    rsp0_ready = 0; rsp1_ready = 0;
    @(negedge clk);
    o.r0 = req0_ready; o.r1 = req1_ready;
    if (o.r0 && o.r1) o.bad = 1;
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    @(negedge clk);
    o.rd = mem_read; o.wr = mem_write; o.addr = mem_addr; o.wdata = mem_wdata;
    if (req0_ready || req1_ready) o.bad = 1;
    @(posedge clk); #1;
    for (int i = 0; i < hold; i++) begin
      req0_valid = 1; req1_valid = 1;
      @(negedge clk);
      if (req0_ready || req1_ready) o.bad = 1;
      if (i == 0) begin
        sv0 = rsp0_valid; sv1 = rsp1_valid; s0 = rsp0_rdata; s1 = rsp1_rdata;
      end else if ({sv0, sv1, s0, s1} !== {rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata}) o.unst = 1;
      @(posedge clk); #1;
    end
    req0_valid = 0; req1_valid = 0; rsp0_ready = 1; rsp1_ready = 1;
    @(negedge clk);
    o.v0 = rsp0_valid; o.v1 = rsp1_valid; o.d0 = rsp0_rdata; o.d1 = rsp1_rdata;
    if (req0_ready || req1_ready) o.bad = 1;
    if (hold > 0 && {sv0, sv1, s0, s1} !== {rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata}) o.unst = 1;
    @(posedge clk); #1;
    rsp0_ready = 0; rsp1_ready = 0;
    @(negedge clk);
    o.idle = !rsp0_valid && !rsp1_valid;
  endtask

  task automatic test_reset();
    req0_valid = 1; req1_valid = 1;
    #2;
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL reset_outputs: got %h want 0", all_out); end
    req0_valid = 0; req1_valid = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL post_reset_idle: got %h want 0", all_out); end
    last_m = 1;
  endtask

  task automatic test_write_read();
    obs_t o;
    logic [63:0] d = 64'hDEADBEEF_CAFEF00D;
    run_txn(1, 0, 1, 0, 8'h05, 8'h00, d, '0, 0, o);
    checks++;
    if (!(o.r0 && !o.r1)) begin errors++; $display("FAIL wr_ready: got r0=%0b r1=%0b want r0 only", o.r0, o.r1); end
    checks++;
    if ({o.wr, o.rd} !== 2'b10 || o.addr !== 64'h5 || o.wdata !== d) begin
      errors++; $display("FAIL wr_strobe: got wr=%0b rd=%0b addr=%h wdata=%h want write to 5 of %h", o.wr, o.rd, o.addr, o.wdata, d);
    end
    checks++;
    if (!(o.v0 && !o.v1 && o.d0 === '0 && !o.bad && o.idle)) begin
      errors++; $display("FAIL wr_rsp: got v0=%0b v1=%0b d0=%h bad=%0b idle=%0b want v0 d0=0", o.v0, o.v1, o.d0, o.bad, o.idle);
    end
    ref_mem[5] = d; last_m = 0;
    run_txn(1, 0, 0, 0, 8'h05, 8'h00, '0, '0, 0, o);
    checks++;
    if ({o.wr, o.rd} !== 2'b01) begin errors++; $display("FAIL rd_strobe: got wr=%0b rd=%0b want rd only", o.wr, o.rd); end
    checks++;
    if (!(o.v0 && !o.v1 && o.d0 === d)) begin
      errors++; $display("FAIL rd_after_wr: got v0=%0b v1=%0b d0=%h want %h", o.v0, o.v1, o.d0, d);
    end
    last_m = 0;
  endtask

  task automatic test_fairness();
    obs_t o;
    int gcount = 0, last_cyc = -10, pend_cyc = -10;
    bit pend_port = 0, exp_p;
    logic [63:0] da = {$urandom, $urandom}, db = {$urandom, $urandom};
    run_txn(1, 0, 1, 0, 8'h10, 8'h00, da, '0, 0, o);
    ref_mem[8'h10] = da;
    run_txn(0, 1, 0, 1, 8'h00, 8'h20, '0, db, 0, o);
    ref_mem[8'h20] = db; last_m = 1;
    exp_p = ~last_m;
    @(posedge clk); #1;
    req0_valid = 1; req1_valid = 1; req0_we = 0; req1_we = 0;
    req0_addr = 8'h10; req1_addr = 8'h20; rsp0_ready = 1; rsp1_ready = 1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (c == pend_cyc + 1) begin
        checks++;
        if (!mem_read || mem_write || mem_addr !== (pend_port ? 64'h20 : 64'h10)) begin
          errors++; $display("FAIL rr_access c%0d: got rd=%0b addr=%h want port %0d addr", c, mem_read, mem_addr, pend_port);
        end
      end
      if (c == pend_cyc + 2) begin
        checks++;
        if ((pend_port ? {rsp1_valid, rsp0_valid, rsp1_rdata} : {rsp0_valid, rsp1_valid, rsp0_rdata})
            !== {2'b10, ref_mem[pend_port ? 8'h20 : 8'h10]}) begin
          errors++; $display("FAIL rr_rsp c%0d: got v0=%0b v1=%0b d0=%h d1=%h want port %0d", c, rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata, pend_port);
        end
      end
      if (req0_ready || req1_ready) begin
        checks++;
        if ((req0_ready && req1_ready) || req1_ready !== exp_p) begin
          errors++; $display("FAIL rr_grant c%0d: got r0=%0b r1=%0b want port %0d", c, req0_ready, req1_ready, exp_p);
        end
        if (gcount > 0) begin
          checks++;
          if (c - last_cyc != 3) begin errors++; $display("FAIL rr_gap c%0d: got %0d want 3", c, c - last_cyc); end
        end
        pend_port = req1_ready; pend_cyc = c; last_cyc = c; gcount++; exp_p = ~exp_p;
      end
    end
    checks++;
    if (gcount != 10) begin errors++; $display("FAIL rr_count: got %0d want 10", gcount); end
    last_m = ~exp_p;
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    repeat (3) @(posedge clk);
    #1 rsp0_ready = 0; rsp1_ready = 0;
  endtask

  task automatic test_backpressure();
    obs_t o;
    run_txn(0, 1, 0, 0, 8'h00, 8'h20, '0, '0, 5, o);
    checks++;
    if (!(o.r1 && !o.r0 && o.rd)) begin errors++; $display("FAIL bp_grant: got r0=%0b r1=%0b rd=%0b want r1 rd", o.r0, o.r1, o.rd); end
    checks++;
    if (o.bad || o.unst) begin errors++; $display("FAIL bp_hold: got bad=%0b unstable=%0b want 0 0", o.bad, o.unst); end
    checks++;
    if (!(o.v1 && !o.v0 && o.d1 === ref_mem[8'h20] && o.idle)) begin
      errors++; $display("FAIL bp_rsp: got v1=%0b d1=%h idle=%0b want %h", o.v1, o.d1, o.idle, ref_mem[8'h20]);
    end
    last_m = 1;
  endtask

  task automatic test_reset_access();
    obs_t o;
    @(posedge clk); #1;
    req0_valid = 1; req0_we = 1; req0_addr = 8'h07; req0_wdata = 64'h1234;
    @(negedge clk);
    checks++;
    if (!req0_ready) begin errors++; $display("FAIL rst_pre_grant: got r0=%0b want 1", req0_ready); end
    @(posedge clk); #1;
    checks++;
    if (!mem_write) begin errors++; $display("FAIL rst_in_access: got wr=%0b want 1", mem_write); end
    rst_n = 0;
    #1;
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL rst_async: got %h want 0", all_out); end
    repeat (2) @(posedge clk);
    #1 req0_valid = 0; req0_we = 0; rst_n = 1; last_m = 1;
    run_txn(1, 1, 0, 0, 8'h07, 8'h07, '0, '0, 0, o);
    checks++;
    if (!(o.r0 && !o.r1)) begin errors++; $display("FAIL rst_first_tie: got r0=%0b r1=%0b want r0", o.r0, o.r1); end
    checks++;
    if (!(o.v0 && o.d0 === ref_mem[7])) begin errors++; $display("FAIL rst_no_commit: got v0=%0b d0=%h want %h", o.v0, o.d0, ref_mem[7]); end
    last_m = 0;
  endtask

  task automatic test_addr_max();
    obs_t o;
    logic [63:0] d = {$urandom, $urandom};
    run_txn(1, 0, 1, 0, 8'hFF, 8'h00, d, '0, 0, o);
    ref_mem[8'hFF] = d;
    run_txn(1, 0, 0, 0, 8'hFF, 8'h00, '0, '0, 1, o);
    checks++;
    if (o.addr !== 64'h00000000_000000FF) begin errors++; $display("FAIL max_addr: got %h want ff", o.addr); end
    checks++;
    if (!(o.v0 && o.d0 === d)) begin errors++; $display("FAIL max_data: got v0=%0b d0=%h want %h", o.v0, o.d0, d); end
    last_m = 0;
  endtask

  task automatic test_port1_write();
    obs_t o;
    logic [63:0] d = {$urandom, $urandom};
    run_txn(0, 1, 0, 1, 8'h00, 8'h33, '0, d, 1, o);
    checks++;
    if (!(o.r1 && o.wr && !o.rd)) begin errors++; $display("FAIL p1w_strobe: got r1=%0b wr=%0b rd=%0b want 1 1 0", o.r1, o.wr, o.rd); end
    checks++;
    if (!(o.v1 && !o.v0 && o.d1 === '0)) begin errors++; $display("FAIL p1w_rsp: got v1=%0b v0=%0b d1=%h want 1 0 0", o.v1, o.v0, o.d1); end
    ref_mem[8'h33] = d; last_m = 1;
  endtask

  task automatic test_random();
    obs_t o;
    for (int k = 0; k < 40; k++) begin
      int pat = $urandom_range(1, 3);
      bit v0 = pat[0], v1 = pat[1], w0 = $urandom_range(0, 1), w1 = $urandom_range(0, 1);
      logic [7:0] a0 = $urandom_range(0, 15), a1 = $urandom_range(0, 15);
      logic [63:0] d0 = {$urandom, $urandom}, d1 = {$urandom, $urandom};
      bit ew = (v0 && v1) ? !last_m : v1;
      bit ewe = ew ? w1 : w0;
      logic [7:0] ea = ew ? a1 : a0;
      logic [63:0] ed = ewe ? 64'h0 : ref_mem[ea];
      run_txn(v0, v1, w0, w1, a0, a1, d0, d1, $urandom_range(0, 3), o);
      checks++;
      if ({o.r1, o.r0} !== (ew ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL rnd%0d grant: got r0=%0b r1=%0b want port %0d", k, o.r0, o.r1, ew);
      end
      checks++;
      if ({o.wr, o.rd} !== {ewe, !ewe} || o.addr !== {56'h0, ea}) begin
        errors++; $display("FAIL rnd%0d access: got wr=%0b rd=%0b addr=%h want we=%0b addr=%h", k, o.wr, o.rd, o.addr, ewe, ea);
      end
      checks++;
      if ({o.v0, o.v1, o.d0, o.d1} !== (ew ? {2'b01, 64'h0, ed} : {2'b10, ed, 64'h0})) begin
        errors++; $display("FAIL rnd%0d rsp: got v0=%0b v1=%0b d0=%h d1=%h want port %0d data %h", k, o.v0, o.v1, o.d0, o.d1, ew, ed);
      end
      checks++;
      if (o.bad || o.unst || !o.idle) begin
        errors++; $display("FAIL rnd%0d protocol: got bad=%0b unstable=%0b idle=%0b want 0 0 1", k, o.bad, o.unst, o.idle);
      end
      if (ewe) ref_mem[ea] = ew ? d1 : d0;
      last_m = ew;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    rst_n = 0;
    req0_valid = 0; req1_valid = 0; req0_we = 0; req1_we = 0;
    req0_addr = '0; req1_addr = '0; req0_wdata = '0; req1_wdata = '0;
    rsp0_ready = 0; rsp1_ready = 0;
    test_reset();
    test_write_read();
    test_fairness();
    test_backpressure();
    test_reset_access();
    test_addr_max();
    test_port1_write();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
